// File: rtl/ip_seq.sv
// Registered instruction-pointer sequencer with a circular hardware return stack.
// Define IP_RSTACK_CHECK_EN to suppress overflowing pushes / underflowing pops and flag them in rs_err.
module ip_seq #(
   parameter int                     IADDR_WIDTH = 10,
   parameter int                     RDEPTH      = 16,
   parameter logic [IADDR_WIDTH-1:0] RESET_IP    = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [2:0]                   op,
   input  logic [IADDR_WIDTH-1:0]       ip_imm,
   input  logic [IADDR_WIDTH-1:0]       TOS,
   input  logic                         TOS_is_zero,
   output logic [IADDR_WIDTH-1:0]       ip,
   output logic [IADDR_WIDTH-1:0]       rs_top,
   output logic [$clog2(RDEPTH+1)-1:0]  rs_depth,
   output logic [1:0]                   rs_err
);

   localparam int SPW = $clog2(RDEPTH);
   localparam int DW  = $clog2(RDEPTH+1);

   typedef enum logic [2:0] {
      OP_NEXT   = 3'd0,
      OP_JMP    = 3'd1,
      OP_JZ     = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_JTOS   = 3'd5,
      OP_SKIPNZ = 3'd6,
      OP_CALLT  = 3'd7
   } op_e;

   logic [IADDR_WIDTH-1:0] rs_buf [RDEPTH];
   logic [SPW-1:0]         sp;
   logic [IADDR_WIDTH-1:0] ip_inc, ip_inc2, ip_nxt;
   logic                   is_push, is_pop;
   logic                   do_push, do_pop, push_ok, pop_ok;
   logic                   full, empty;

   assign ip_inc  = ip + IADDR_WIDTH'(1);
   assign ip_inc2 = ip + IADDR_WIDTH'(2);
   assign rs_top  = rs_buf[sp - SPW'(1)];
   assign full    = (rs_depth == DW'(RDEPTH));
   assign empty   = (rs_depth == '0);

   always_comb begin
      ip_nxt  = ip_inc;
      is_push = 1'b0;
      is_pop  = 1'b0;
      case (op_e'(op))
         OP_NEXT:   ip_nxt = ip_inc;
         OP_JMP:    ip_nxt = ip_imm;
         OP_JZ:     ip_nxt = TOS_is_zero ? ip_imm : ip_inc;
         OP_CALL:   begin ip_nxt = ip_imm; is_push = 1'b1; end
         OP_RET:    begin ip_nxt = rs_top; is_pop  = 1'b1; end
         OP_JTOS:   ip_nxt = TOS;
         OP_SKIPNZ: ip_nxt = TOS_is_zero ? ip_inc : ip_inc2;
         OP_CALLT:  begin ip_nxt = TOS;    is_push = 1'b1; end
         default:   ip_nxt = ip_inc;
      endcase
   end

   assign do_push = en & is_push;
   assign do_pop  = en & is_pop;

`ifdef IP_RSTACK_CHECK_EN
   // Out-of-range stack ops still redirect ip but leave sp and the buffer alone.
   assign push_ok = do_push & ~full;
   assign pop_ok  = do_pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         rs_err <= 2'b00;
      end else begin
         if (do_push && full)  rs_err[0] <= 1'b1;
         if (do_pop  && empty) rs_err[1] <= 1'b1;
      end
   end
`else
   assign push_ok = do_push;
   assign pop_ok  = do_pop;
   assign rs_err  = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ip       <= RESET_IP;
         sp       <= '0;
         rs_depth <= '0;
      end else if (en) begin
         ip <= ip_nxt;
         if (push_ok)     sp <= sp + SPW'(1);
         else if (pop_ok) sp <= sp - SPW'(1);
         // Depth saturates even when sp is allowed to wrap.
         if (do_push && !full)      rs_depth <= rs_depth + DW'(1);
         else if (do_pop && !empty) rs_depth <= rs_depth - DW'(1);
      end
   end

   // Storage has no reset; a push coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) rs_buf[sp] <= ip_inc;
   end

endmodule

// File: tb/tb_ip_seq.sv
// Scoreboard bench for ip_seq: queue-based return-stack model, directed plan cases then random ops.
module tb_ip_seq;
   localparam int AW = 10;
   localparam int RD = 16;
   localparam int DW = 5;
   localparam logic [AW-1:0] RIP = 10'h3F0;

   typedef struct {
      logic [AW-1:0] ip;
      logic [DW-1:0] depth;
      logic [1:0]    err;
      logic [AW-1:0] top;
      bit            top_vld;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, en, TOS_is_zero;
   logic [2:0]    op;
   logic [AW-1:0] ip_imm, TOS;
   logic [AW-1:0] ip, rs_top;
   logic [DW-1:0] rs_depth;
   logic [1:0]    rs_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_t          sb[$];
   logic [AW-1:0] stk[$];   // return addresses, newest at back
   logic [AW-1:0] plog[$];  // every accepted push since reset, in order
   logic [AW-1:0] m_ip;
   logic [1:0]    m_err;

   ip_seq #(.IADDR_WIDTH(AW), .RDEPTH(RD), .RESET_IP(RIP)) dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .ip_imm(ip_imm), .TOS(TOS),
      .TOS_is_zero(TOS_is_zero), .ip(ip), .rs_top(rs_top), .rs_depth(rs_depth),
      .rs_err(rs_err)
   );

   always #5 clk = ~clk;

   task automatic m_push(input logic [AW-1:0] a);
      if (stk.size() == RD) begin
`ifdef IP_RSTACK_CHECK_EN
         m_err[0] = 1'b1;
`else
         void'(stk.pop_front());
         stk.push_back(a);
         plog.push_back(a);
`endif
      end else begin
         stk.push_back(a);
         plog.push_back(a);
      end
   endtask

   // Next architectural state from the op semantics; an empty RET returns the slot
   // below sp=0, which after exactly RD pushes from reset is the RD-th push.
   task automatic model(input logic r, input logic e, input logic [2:0] o,
                        input logic [AW-1:0] imm, input logic [AW-1:0] tos, input logic tz);
      logic [AW-1:0] inc;
      inc = m_ip + 1;
      if (r) begin
         m_ip = RIP; m_err = 2'b00;
         stk.delete(); plog.delete();
      end else if (e) begin
         case (o)
            3'd0: m_ip = inc;
            3'd1: m_ip = imm;
            3'd2: m_ip = tz ? imm : inc;
            3'd3: begin m_push(inc); m_ip = imm; end
            3'd4: begin
               if (stk.size() > 0) m_ip = stk.pop_back();
               else begin
                  m_ip = plog[RD-1];
`ifdef IP_RSTACK_CHECK_EN
                  m_err[1] = 1'b1;
`endif
               end
            end
            3'd5: m_ip = tos;
            3'd6: m_ip = tz ? inc : m_ip + 2;
            default: begin m_push(inc); m_ip = tos; end
         endcase
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [2:0] o,
                        input logic [AW-1:0] imm, input logic [AW-1:0] tos, input logic tz);
      exp_t x;
      reset = r; en = e; op = o; ip_imm = imm; TOS = tos; TOS_is_zero = tz;
      model(r, e, o, imm, tos, tz);
      x.ip = m_ip; x.depth = DW'(stk.size()); x.err = m_err;
      x.top_vld = (stk.size() > 0);
      x.top = x.top_vld ? stk[$] : '0;
      sb.push_back(x);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("ip", ip, x.ip);
            chk("rs_depth", AW'(rs_depth), AW'(x.depth));
            chk("rs_err", AW'(rs_err), AW'(x.err));
            if (x.top_vld) chk("rs_top", rs_top, x.top);
         end
      end
   end

   initial begin : stim
      logic [2:0]    o;
      logic [AW-1:0] t;
      int            wait_cyc;
      m_ip = '0; m_err = '0;
      // reset, then NEXT from 0x3F0
      drive(1, 1, 3'd4, 10'h000, 10'h000, 0);
      repeat (3) drive(0, 1, 3'd0, 10'h155, 10'h2AA, 0);
      // call / return at 0x010
      drive(0, 1, 3'd1, 10'h010, 10'h000, 0);
      drive(0, 1, 3'd3, 10'h100, 10'h000, 0);
      drive(0, 1, 3'd0, 10'h000, 10'h000, 0);
      drive(0, 1, 3'd0, 10'h000, 10'h000, 0);
      drive(0, 1, 3'd4, 10'h000, 10'h000, 0);
      // conditional branches and wrap
      drive(0, 1, 3'd1, 10'h020, 10'h000, 0);
      drive(0, 1, 3'd2, 10'h080, 10'h000, 1);
      drive(0, 1, 3'd1, 10'h020, 10'h000, 0);
      drive(0, 1, 3'd2, 10'h080, 10'h005, 0);
      drive(0, 1, 3'd1, 10'h3FF, 10'h000, 0);
      drive(0, 1, 3'd6, 10'h000, 10'h007, 0);
      drive(0, 1, 3'd6, 10'h000, 10'h000, 1);
      drive(0, 1, 3'd5, 10'h000, 10'h1C3, 0);
      // stall with CALL pending on the inputs
      drive(0, 1, 3'd7, 10'h000, 10'h200, 0);
      repeat (4) drive(0, 0, 3'd3, 10'h0AB, 10'h0CD, 0);
      drive(0, 1, 3'd4, 10'h000, 10'h000, 0);
      // stack overflow then full drain
      drive(1, 1, 3'd0, 10'h000, 10'h000, 0);
      for (int i = 0; i < RD + 1; i++) drive(0, 1, 3'd3, AW'(10'h100 + i * 16), 10'h000, 0);
      for (int i = 0; i < RD; i++) drive(0, 1, 3'd4, 10'h000, 10'h000, 0);
`ifdef IP_RSTACK_CHECK_EN
      drive(0, 1, 3'd4, 10'h000, 10'h000, 0);
`endif
      drive(0, 1, 3'd0, 10'h000, 10'h000, 0);
      // reset mid call chain with RET presented
      drive(1, 1, 3'd0, 10'h000, 10'h000, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 3'd3, AW'(10'h040 + i * 8), 10'h000, 0);
      drive(1, 1, 3'd4, 10'h000, 10'h000, 0);
      drive(0, 1, 3'd0, 10'h000, 10'h000, 0);
      // random traffic kept inside the stack bounds
      for (int i = 0; i < 800; i++) begin
         o = 3'($urandom_range(0, 7));
         if (o == 3'd4 && stk.size() == 0) o = 3'd0;
         if ((o == 3'd3 || o == 3'd7) && stk.size() == RD) o = 3'd1;
         t = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, o, AW'($urandom), t,
               (t == '0) ? 1'b1 : ($urandom_range(0, 3) == 0));
      end
      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
